// File: rtl/mmu_arbiter_wrr.sv
// Weighted round-robin DMA request arbiter: merges N_CH region request streams
// onto one DMA port, caps per-channel outstanding work, emits ordering-mux records.

module mmu_arbiter_wrr_ch #(
  parameter int WGT_BITS  = 4,
  parameter int MAX_OUTST = 16,
  parameter int CNT_BITS  = 5
) (
  input  logic                aclk,
  input  logic                areset,
  input  logic                req_valid,
  input  logic [WGT_BITS-1:0] weight,
  input  logic                done,
  input  logic                grant,
  input  logic                reload,
  output logic                elig,
  output logic                want_reload,
  output logic                last_credit,
  output logic [CNT_BITS-1:0] cnt,
  output logic                err
);
  logic [WGT_BITS-1:0] credit_q, credit_d;
  logic [CNT_BITS-1:0] cnt_q, cnt_d;
  logic                err_q, err_d;
  logic                avail;

  // avail: everything except credit allows a grant
  assign avail       = req_valid && (weight != '0) && (cnt_q < CNT_BITS'(MAX_OUTST));
  assign elig        = avail && (credit_q != '0);
  assign want_reload = avail && (credit_q == '0);
  assign last_credit = (credit_q == WGT_BITS'(1));
  assign cnt         = cnt_q;
  assign err         = err_q;

  always_comb begin
    credit_d = credit_q;
    cnt_d    = cnt_q;
    err_d    = err_q;
    if (reload)     credit_d = weight;
    else if (grant) credit_d = credit_q - 1'b1;
    if (grant && !done) begin
      cnt_d = cnt_q + 1'b1;
    end else if (done && !grant) begin
      if (cnt_q == '0) err_d = 1'b1;
      else             cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      credit_q <= '0;
      cnt_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      credit_q <= credit_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
    end
  end
endmodule

module mmu_arbiter_wrr #(
  parameter int N_CH      = 4,
  parameter int REQ_BITS  = 96,
  parameter int LEN_BITS  = 28,
  parameter int WGT_BITS  = 4,
  parameter int MAX_OUTST = 16,
  parameter int ID_BITS   = $clog2(N_CH),
  parameter int CNT_BITS  = $clog2(MAX_OUTST+1)
) (
  input  logic                     aclk,
  input  logic                     areset,
  input  logic [N_CH-1:0]          s_req_valid,
  output logic [N_CH-1:0]          s_req_ready,
  input  logic [N_CH*REQ_BITS-1:0] s_req_data,
  input  logic [N_CH*LEN_BITS-1:0] s_req_len,
  input  logic [N_CH*WGT_BITS-1:0] weight,
  input  logic [N_CH-1:0]          xfer_done,
  output logic                     m_req_valid,
  input  logic                     m_req_ready,
  output logic [REQ_BITS-1:0]      m_req_data,
  output logic                     m_mux_valid,
  input  logic                     m_mux_ready,
  output logic [ID_BITS-1:0]       m_mux_id,
  output logic [LEN_BITS-1:0]      m_mux_len,
  output logic [N_CH*CNT_BITS-1:0] outst_cnt,
  output logic [N_CH-1:0]          err_underflow,
  output logic                     busy
);
  typedef enum logic {ARB, ISSUE} state_e;

  state_e              state_q, state_d;
  logic [ID_BITS-1:0]  rr_q, rr_d;
  logic                req_pend_q, req_pend_d;
  logic                mux_pend_q, mux_pend_d;
  logic [REQ_BITS-1:0] data_q, data_d;
  logic [ID_BITS-1:0]  id_q, id_d;
  logic [LEN_BITS-1:0] len_q, len_d;

  logic [N_CH-1:0]     elig, want_reload, last_credit, gnt_vec;
  logic                gnt_found, reload;
  logic [ID_BITS-1:0]  gnt_idx, gnt_nxt;

  genvar gi;
  generate
    for (gi = 0; gi < N_CH; gi++) begin : g_ch
      mmu_arbiter_wrr_ch #(
        .WGT_BITS (WGT_BITS),
        .MAX_OUTST(MAX_OUTST),
        .CNT_BITS (CNT_BITS)
      ) u_ch (
        .aclk       (aclk),
        .areset     (areset),
        .req_valid  (s_req_valid[gi]),
        .weight     (weight[gi*WGT_BITS +: WGT_BITS]),
        .done       (xfer_done[gi]),
        .grant      (gnt_vec[gi]),
        .reload     (reload),
        .elig       (elig[gi]),
        .want_reload(want_reload[gi]),
        .last_credit(last_credit[gi]),
        .cnt        (outst_cnt[gi*CNT_BITS +: CNT_BITS]),
        .err        (err_underflow[gi])
      );
    end
  endgenerate

  // First eligible channel scanning upward from the rr pointer, with wrap
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    for (int k = 0; k < N_CH; k++) begin
      int idx;
      idx = int'(rr_q) + k;
      if (idx >= N_CH) idx = idx - N_CH;
      if (!gnt_found && elig[idx]) begin
        gnt_found = 1'b1;
        gnt_idx   = ID_BITS'(idx);
      end
    end
  end

  always_comb begin
    for (int i = 0; i < N_CH; i++)
      gnt_vec[i] = (state_q == ARB) && gnt_found && (gnt_idx == ID_BITS'(i));
  end

  // New round only when credit is the sole thing blocking every channel
  assign reload      = (state_q == ARB) && !gnt_found && (|want_reload);
  assign gnt_nxt     = (gnt_idx == ID_BITS'(N_CH-1)) ? '0 : gnt_idx + 1'b1;
  assign s_req_ready = gnt_vec;

  always_comb begin
    state_d    = state_q;
    rr_d       = rr_q;
    req_pend_d = req_pend_q;
    mux_pend_d = mux_pend_q;
    data_d     = data_q;
    id_d       = id_q;
    len_d      = len_q;
    case (state_q)
      ARB: begin
        if (gnt_found) begin
          state_d    = ISSUE;
          req_pend_d = 1'b1;
          mux_pend_d = 1'b1;
          data_d     = s_req_data[int'(gnt_idx)*REQ_BITS +: REQ_BITS];
          len_d      = s_req_len[int'(gnt_idx)*LEN_BITS +: LEN_BITS];
          id_d       = gnt_idx;
          // pointer parks on a channel until its credit for this round is spent
          if (last_credit[gnt_idx]) rr_d = gnt_nxt;
        end
      end
      ISSUE: begin
        if (m_req_ready) req_pend_d = 1'b0;
        if (m_mux_ready) mux_pend_d = 1'b0;
        if (!req_pend_d && !mux_pend_d) state_d = ARB;
      end
      default: state_d = ARB;
    endcase
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_q    <= ARB;
      rr_q       <= '0;
      req_pend_q <= 1'b0;
      mux_pend_q <= 1'b0;
      data_q     <= '0;
      id_q       <= '0;
      len_q      <= '0;
    end else begin
      state_q    <= state_d;
      rr_q       <= rr_d;
      req_pend_q <= req_pend_d;
      mux_pend_q <= mux_pend_d;
      data_q     <= data_d;
      id_q       <= id_d;
      len_q      <= len_d;
    end
  end

  assign m_req_valid = req_pend_q;
  assign m_mux_valid = mux_pend_q;
  assign m_req_data  = data_q;
  assign m_mux_id    = id_q;
  assign m_mux_len   = len_q;
  assign busy        = (state_q != ARB) || (|outst_cnt);
endmodule

// File: tb/tb_mmu_arbiter_wrr.sv
// Directed bench for mmu_arbiter_wrr: expected ids are queued by the stimulus,
// a negedge monitor pops and checks each req / mux handshake.

module tb_mmu_arbiter_wrr;
  localparam int N = 4, RB = 96, LB = 28, WB = 4, MO = 4, IB = 2, CB = 3;

  logic              aclk = 1'b0;
  logic              areset;
  logic [N-1:0]      s_req_valid, s_req_ready, xfer_done, err_underflow;
  logic [N*RB-1:0]   s_req_data;
  logic [N*LB-1:0]   s_req_len;
  logic [N*WB-1:0]   weight;
  logic              m_req_valid, m_req_ready, m_mux_valid, m_mux_ready, busy;
  logic [RB-1:0]     m_req_data;
  logic [IB-1:0]     m_mux_id;
  logic [LB-1:0]     m_mux_len;
  logic [N*CB-1:0]   outst_cnt;

  int checks = 0, failures = 0, cyc = 0;
  int exp_req_q[$], exp_mux_q[$];
  int rid, mid;

  mmu_arbiter_wrr #(
    .N_CH(N), .REQ_BITS(RB), .LEN_BITS(LB), .WGT_BITS(WB), .MAX_OUTST(MO)
  ) dut (
    .aclk(aclk), .areset(areset),
    .s_req_valid(s_req_valid), .s_req_ready(s_req_ready),
    .s_req_data(s_req_data), .s_req_len(s_req_len), .weight(weight),
    .xfer_done(xfer_done),
    .m_req_valid(m_req_valid), .m_req_ready(m_req_ready), .m_req_data(m_req_data),
    .m_mux_valid(m_mux_valid), .m_mux_ready(m_mux_ready),
    .m_mux_id(m_mux_id), .m_mux_len(m_mux_len),
    .outst_cnt(outst_cnt), .err_underflow(err_underflow), .busy(busy)
  );

  always #5 aclk = ~aclk;
  always @(posedge aclk) cyc <= cyc + 1;

  function automatic logic [RB-1:0] data_of(input int id);
    return {32'hA5A5_0000 | 32'(id), 32'h1234_5600 | 32'(id), 32'hC0DE_0000 | 32'(id)};
  endfunction

  function automatic logic [LB-1:0] len_of(input int id);
    return LB'(id * 16 + 5);
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic push(input int id);
    exp_req_q.push_back(id);
    exp_mux_q.push_back(id);
  endtask

  task automatic do_reset();
    areset      = 1'b1;
    xfer_done   = '0;
    m_req_ready = 1'b0;
    m_mux_ready = 1'b0;
    #3;
    tick();
    tick();
  endtask

  task automatic drain();
    for (int c = 0; c < 50 && (exp_req_q.size() != 0 || exp_mux_q.size() != 0); c++) tick();
    chk("drain_req_q", exp_req_q.size(), 0);
    chk("drain_mux_q", exp_mux_q.size(), 0);
    exp_req_q.delete();
    exp_mux_q.delete();
  endtask

  // Scoreboard monitor: each handshake seen before the edge must match the queue head
  always @(negedge aclk) begin
    if (!areset) begin
      if (m_req_valid && m_req_ready) begin
        if (exp_req_q.size() == 0) chk("req_unexpected_qsize", exp_req_q.size(), 1);
        else begin
          rid = exp_req_q.pop_front();
          chk("req_data", m_req_data, data_of(rid));
        end
      end
      if (m_mux_valid && m_mux_ready) begin
        if (exp_mux_q.size() == 0) chk("mux_unexpected_qsize", exp_mux_q.size(), 1);
        else begin
          mid = exp_mux_q.pop_front();
          chk("mux_id", m_mux_id, mid);
          chk("mux_len", m_mux_len, len_of(mid));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    int first_rdy, vcnt, ng, ng2, ch2g;
    int vcyc[5];
    logic [N-1:0] pend;

    for (int i = 0; i < N; i++) begin
      s_req_data[i*RB +: RB] = data_of(i);
      s_req_len[i*LB +: LB]  = len_of(i);
    end
    weight      = {N{4'd1}};
    s_req_valid = '1;
    do_reset();
    chk("rst_s_req_ready", s_req_ready, 0);
    chk("rst_valids", {m_req_valid, m_mux_valid}, 0);
    chk("rst_data", m_req_data, 0);
    chk("rst_id_len", {m_mux_id, m_mux_len}, 0);
    chk("rst_outst", outst_cnt, 0);
    chk("rst_err", err_underflow, 0);
    chk("rst_busy", busy, 0);

    // T1: equal weights, plain rotation
    areset = 1'b0; m_req_ready = 1'b1; m_mux_ready = 1'b1;
    push(0); push(1); push(2); push(3); push(0);
    first_rdy = -1; vcnt = 0;
    for (int c = 0; c < 60 && vcnt < 5; c++) begin
      if (s_req_ready[0] && first_rdy < 0) first_rdy = cyc;
      if (m_req_valid) begin vcyc[vcnt] = cyc; vcnt++; end
      if (vcnt == 5) s_req_valid = '0;
      else tick();
    end
    chk("t1_issue_count", vcnt, 5);
    chk("t1_latency", vcyc[0], first_rdy + 1);
    chk("t1_gap01", vcyc[1] - vcyc[0], 2);
    chk("t1_gap12", vcyc[2] - vcyc[1], 2);
    chk("t1_gap23", vcyc[3] - vcyc[2], 2);
    drain();
    tick();
    chk("t1_outst", outst_cnt, {3'd1, 3'd1, 3'd1, 3'd2});
    chk("t1_busy", busy, 1);

    // T2: weights {3,1,0,2}, done pulsed one cycle after each grant
    do_reset();
    areset = 1'b0; m_req_ready = 1'b1; m_mux_ready = 1'b1;
    weight = {4'd2, 4'd0, 4'd1, 4'd3};
    s_req_valid = '1;
    for (int r = 0; r < 2; r++) begin push(0); push(0); push(0); push(1); push(3); push(3); end
    pend = '0; ng = 0; ch2g = 0;
    for (int c = 0; c < 100 && ng < 12; c++) begin
      xfer_done = pend;
      pend = s_req_ready;
      if (s_req_ready != '0) ng++;
      if (s_req_ready[2]) ch2g++;
      tick();
    end
    s_req_valid = '0;
    xfer_done = pend;
    tick();
    xfer_done = '0;
    chk("t2_grants", ng, 12);
    chk("t2_ch2_grants", ch2g, 0);
    drain();
    chk("t2_outst", outst_cnt, 0);
    chk("t2_err", err_underflow, 0);

    // T3: outstanding cap on ch1
    do_reset();
    areset = 1'b0; m_req_ready = 1'b1; m_mux_ready = 1'b1;
    weight = {N{4'd1}};
    s_req_valid = 4'b0010;
    for (int i = 0; i < MO; i++) push(1);
    ng = 0;
    for (int c = 0; c < 40; c++) begin
      if (s_req_ready != '0) ng++;
      tick();
    end
    chk("t3_grants_to_cap", ng, MO);
    chk("t3_cnt1", outst_cnt[1*CB +: CB], MO);
    chk("t3_busy", busy, 1);
    chk("t3_stalled", s_req_ready, 0);
    xfer_done = 4'b0010;
    tick();
    xfer_done = '0;
    push(1);
    ng2 = 0;
    for (int c = 0; c < 20; c++) begin
      if (s_req_ready != '0) ng2++;
      tick();
    end
    chk("t3_one_more", ng2, 1);
    chk("t3_cnt1_again", outst_cnt[1*CB +: CB], MO);
    s_req_valid = '0;
    drain();

    // T4: mux side back-pressured while req side accepts
    do_reset();
    areset = 1'b0; m_req_ready = 1'b1; m_mux_ready = 1'b0;
    s_req_valid = 4'b0100;
    push(2);
    ng = 0;
    for (int c = 0; c < 10 && s_req_ready == '0; c++) tick();
    chk("t4_grant", s_req_ready, 4'b0100);
    tick();
    for (int k = 0; k < 5; k++) begin
      chk("t4_req_valid", m_req_valid, (k == 0));
      chk("t4_mux_valid", m_mux_valid, 1);
      chk("t4_mux_id", m_mux_id, 2);
      chk("t4_mux_len", m_mux_len, len_of(2));
      chk("t4_no_grant", s_req_ready, 0);
      tick();
    end
    s_req_valid = '0;
    m_mux_ready = 1'b1;
    tick();
    chk("t4_mux_done", m_mux_valid, 0);
    drain();

    // T5: underflow flag and simultaneous grant/done
    do_reset();
    areset = 1'b0; m_req_ready = 1'b1; m_mux_ready = 1'b1;
    s_req_valid = '0;
    xfer_done = 4'b0100;
    tick();
    xfer_done = '0;
    chk("t5_cnt2", outst_cnt[2*CB +: CB], 0);
    chk("t5_err", err_underflow, 4'b0100);
    tick(); tick(); tick();
    chk("t5_err_sticky", err_underflow, 4'b0100);
    s_req_valid = 4'b0001;
    for (int i = 0; i < 4; i++) push(0);
    ng = 0;
    for (int c = 0; c < 40 && ng < 4; c++) begin
      if (s_req_ready[0]) begin
        if (ng == 3) begin
          chk("t5_cnt0_pre", outst_cnt[0 +: CB], 3);
          xfer_done = 4'b0001;
        end
        ng++;
      end
      tick();
      xfer_done = '0;
    end
    s_req_valid = '0;
    chk("t5_grants", ng, 4);
    chk("t5_cnt0_same", outst_cnt[0 +: CB], 3);
    chk("t5_err_final", err_underflow, 4'b0100);
    drain();

    // T6: async reset while in ISSUE
    do_reset();
    areset = 1'b0; m_req_ready = 1'b0; m_mux_ready = 1'b0;
    s_req_valid = 4'b0100;
    for (int c = 0; c < 10 && !m_req_valid; c++) tick();
    chk("t6_in_issue", m_req_valid, 1);
    #2 areset = 1'b1;
    #1;
    chk("t6_valids", {m_req_valid, m_mux_valid}, 0);
    chk("t6_ready", s_req_ready, 0);
    chk("t6_data", m_req_data, 0);
    chk("t6_id_len", {m_mux_id, m_mux_len}, 0);
    chk("t6_outst", outst_cnt, 0);
    chk("t6_busy", busy, 0);
    tick();
    s_req_valid = '1; m_req_ready = 1'b1; m_mux_ready = 1'b1;
    areset = 1'b0;
    chk("t6_reload_cycle", s_req_ready, 0);
    tick();
    chk("t6_restart_ch0", s_req_ready, 4'b0001);
    push(0);
    tick();
    s_req_valid = '0;
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
